// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Brief    : Write-back stage and general register file. Selects the
//            write-back value, commits it to the register array, serves two
//            combinational read ports with same-cycle write-through bypass,
//            exports the commit for EX forwarding and counts retirements.
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [1:0]        MemtoReg,
    input  logic              connect_zero_WB,
    input  logic [DATA_W-1:0] ALUresult_WB,
    input  logic [DATA_W-1:0] Data_out_WB,
    input  logic [DATA_W-1:0] nextpc_WB,
    input  logic [ADDR_W-1:0] Insaddr_WB,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [CNT_W-1:0]  retire_cnt,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int c_NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [c_NUM_REGS];
    logic [CNT_W-1:0]  r_retire_cnt;
    logic [DATA_W-1:0] w_wb_data;
    logic              w_retire;
    logic              w_commit;

    // An instruction retires when it writes and was not cancelled; it only
    // commits to the array when the destination is not the zero register.
    // Both are gated by RegWrite first so unknown payloads cannot leak in.
    assign w_retire = RegWrite & ~connect_zero_WB;
    assign w_commit = w_retire & (Insaddr_WB != '0);

    // Write-back source select: 01 load data, 10 link PC, else ALU result.
    always_comb begin
        w_wb_data = ALUresult_WB;
        case (MemtoReg)
            2'b01:   w_wb_data = Data_out_WB;
            2'b10:   w_wb_data = nextpc_WB;
            default: w_wb_data = ALUresult_WB;
        endcase
    end

    // Register array: reset clears every entry and wins over a commit.
    // Entry 0 is never written outside reset, so it stays zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[Insaddr_WB] <= w_wb_data;
        end
    end

    // Retire counter: counts cancelled-free writes, including ones to
    // register 0, and wraps silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retire_cnt <= '0;
        end else if (w_retire) begin
            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
        end
    end

    // Read port A: zero register, then same-cycle bypass, then array.
    always_comb begin
        rs_data = r_regs[rs_addr];
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (w_commit && (rs_addr == Insaddr_WB)) begin
            rs_data = w_wb_data;
        end
    end

    // Read port B: same priority as port A.
    always_comb begin
        rt_data = r_regs[rt_addr];
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (w_commit && (rt_addr == Insaddr_WB)) begin
            rt_data = w_wb_data;
        end
    end

    // Debug port shows architectural state only, never the bypass.
    always_comb begin
        dbg_data = r_regs[dbg_addr];
        if (dbg_addr == '0) begin
            dbg_data = '0;
        end
    end

    assign wb_data    = w_wb_data;
    assign wb_we      = w_commit;
    assign wb_addr    = Insaddr_WB;
    assign retire_cnt = r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile
// Brief    : Self-checking bench for wb_regfile. Directed scenarios plus
//            randomized traffic compared against an array-based model of
//            the architectural register state and retire count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [1:0]  MemtoReg;
    logic        connect_zero_WB;
    logic [31:0] ALUresult_WB;
    logic [31:0] Data_out_WB;
    logic [31:0] nextpc_WB;
    logic [4:0]  Insaddr_WB;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  dbg_addr;

    logic [31:0] rs_data, rt_data, wb_data, dbg_data, retire_cnt;
    logic [4:0]  wb_addr;
    logic        wb_we;

    logic [31:0] rs_data4, rt_data4, wb_data4, dbg_data4;
    logic [4:0]  wb_addr4;
    logic        wb_we4;
    logic [3:0]  retire_cnt4;

    int checks   = 0;
    int failures = 0;

    // Reference state: architectural registers and total retirements.
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    wb_regfile u_dut (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .connect_zero_WB(connect_zero_WB), .ALUresult_WB(ALUresult_WB),
        .Data_out_WB(Data_out_WB), .nextpc_WB(nextpc_WB), .Insaddr_WB(Insaddr_WB),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .wb_data(wb_data), .wb_we(wb_we), .wb_addr(wb_addr), .retire_cnt(retire_cnt),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Narrow-counter instance, same stimulus, to observe counter wrap.
    wb_regfile #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .connect_zero_WB(connect_zero_WB), .ALUresult_WB(ALUresult_WB),
        .Data_out_WB(Data_out_WB), .nextpc_WB(nextpc_WB), .Insaddr_WB(Insaddr_WB),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data4), .rt_data(rt_data4),
        .wb_data(wb_data4), .wb_we(wb_we4), .wb_addr(wb_addr4), .retire_cnt(retire_cnt4),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_select();
        if (MemtoReg == 2'd1) return Data_out_WB;
        if (MemtoReg == 2'd2) return nextpc_WB;
        return ALUresult_WB;
    endfunction

    function automatic logic m_commit();
        return RegWrite && !connect_zero_WB && (Insaddr_WB != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_commit() && a == Insaddr_WB) return m_select();
        return m_regs[a];
    endfunction

    task automatic drive(input logic rst, input logic rw, input logic [1:0] sel,
                         input logic cz, input logic [31:0] alu, input logic [31:0] dout,
                         input logic [31:0] npc, input logic [4:0] ins,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dbg);
        reset = rst; RegWrite = rw; MemtoReg = sel; connect_zero_WB = cz;
        ALUresult_WB = alu; Data_out_WB = dout; nextpc_WB = npc; Insaddr_WB = ins;
        rs_addr = rs; rt_addr = rt; dbg_addr = dbg;
    endtask

    task automatic idle(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dbg);
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, rs, rt, dbg);
    endtask

    // One clock: compare all outputs with the model before the edge, then
    // advance the model by the edge's effect.
    task automatic step(input bit chk_en);
        @(negedge clk);
        if (chk_en) begin
            check("wb_data",    wb_data,              m_select());
            check("wb_we",      32'(wb_we),           32'(m_commit()));
            check("wb_addr",    32'(wb_addr),         32'(Insaddr_WB));
            check("rs_data",    rs_data,              m_read(rs_addr));
            check("rt_data",    rt_data,              m_read(rt_addr));
            check("dbg_data",   dbg_data,             m_regs[dbg_addr]);
            check("retire_cnt", retire_cnt,           m_cnt);
            check("retire_cnt4", 32'(retire_cnt4),    {28'd0, m_cnt[3:0]});
        end
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_cnt = 32'd0;
        end else begin
            if (m_commit()) m_regs[Insaddr_WB] = m_select();
            if (RegWrite && !connect_zero_WB) m_cnt = m_cnt + 32'd1;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt = 32'd0;

        // Initial reset; array contents before it are unknown.
        idle(5'd0, 5'd0, 5'd0);
        reset = 1'b1;
        step(1'b0);
        idle(5'd0, 5'd0, 5'd0);
        #2;
        check("reset_cnt", retire_cnt, 32'd0);
        step(1'b1);

        // T1: write reg5, reset, reg5 reads 0 and counter is 0.
        drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h1234, 32'd0, 32'd0, 5'd5, 5'd0, 5'd0, 5'd0);
        step(1'b1);
        idle(5'd5, 5'd0, 5'd5);
        #2;
        check("t1_written", dbg_data, 32'h1234);
        reset = 1'b1;
        step(1'b1);
        idle(5'd5, 5'd0, 5'd5);
        #2;
        check("t1_rs_after_reset", rs_data, 32'd0);
        check("t1_cnt_after_reset", retire_cnt, 32'd0);
        step(1'b1);

        // T2: load data to reg7, link PC to reg31.
        drive(1'b0, 1'b1, 2'd1, 1'b0, 32'd0, 32'hDEADBEEF, 32'd0, 5'd7, 5'd0, 5'd7, 5'd0);
        step(1'b1);
        idle(5'd0, 5'd7, 5'd0);
        #2;
        check("t2_rt_load", rt_data, 32'hDEADBEEF);
        check("t2_cnt", retire_cnt, 32'd1);
        step(1'b1);
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'd0, 32'd0, 32'h00400008, 5'd31, 5'd0, 5'd0, 5'd0);
        step(1'b1);
        idle(5'd0, 5'd0, 5'd31);
        #2;
        check("t2_link_pc", dbg_data, 32'h00400008);
        step(1'b1);

        // T3: bypass on both ports while debug still shows the old value.
        drive(1'b0, 1'b1, 2'd3, 1'b0, 32'h11, 32'd0, 32'd0, 5'd9, 5'd0, 5'd0, 5'd0);
        step(1'b1);
        drive(1'b0, 1'b1, 2'd0, 1'b0, 32'hA5A5A5A5, 32'd0, 32'd0, 5'd9, 5'd9, 5'd9, 5'd9);
        #2;
        check("t3_rs_bypass", rs_data, 32'hA5A5A5A5);
        check("t3_rt_bypass", rt_data, 32'hA5A5A5A5);
        check("t3_dbg_old", dbg_data, 32'h11);
        step(1'b1);
        idle(5'd0, 5'd0, 5'd9);
        #2;
        check("t3_dbg_new", dbg_data, 32'hA5A5A5A5);
        check("t3_cnt", retire_cnt, 32'd4);
        step(1'b1);

        // T4: write to register 0 retires but never commits.
        drive(1'b0, 1'b1, 2'd0, 1'b0, 32'hFFFFFFFF, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 5'd0);
        #2;
        check("t4_rs_zero", rs_data, 32'd0);
        check("t4_we", 32'(wb_we), 32'd0);
        step(1'b1);
        idle(5'd0, 5'd0, 5'd0);
        #2;
        check("t4_rs_zero_next", rs_data, 32'd0);
        check("t4_cnt", retire_cnt, 32'd5);
        step(1'b1);

        // T5: cancelled write has no effect anywhere.
        drive(1'b0, 1'b1, 2'd0, 1'b1, 32'h55, 32'd0, 32'd0, 5'd3, 5'd3, 5'd0, 5'd3);
        #2;
        check("t5_we", 32'(wb_we), 32'd0);
        check("t5_no_bypass", rs_data, 32'd0);
        step(1'b1);
        idle(5'd0, 5'd0, 5'd3);
        #2;
        check("t5_reg3", dbg_data, 32'd0);
        check("t5_cnt", retire_cnt, 32'd5);
        step(1'b1);

        // T6: reset beats a commit; narrow counter wraps after 16.
        drive(1'b1, 1'b1, 2'd0, 1'b0, 32'h77, 32'd0, 32'd0, 5'd12, 5'd0, 5'd0, 5'd0);
        step(1'b1);
        idle(5'd0, 5'd0, 5'd12);
        #2;
        check("t6_reg12", dbg_data, 32'd0);
        check("t6_cnt", retire_cnt, 32'd0);
        step(1'b1);
        for (int n = 0; n < 15; n++) begin
            drive(1'b0, 1'b1, 2'd0, 1'b0, $urandom, 32'd0, 32'd0,
                  5'($urandom_range(1, 31)), 5'd0, 5'd0, 5'd0);
            step(1'b1);
        end
        idle(5'd0, 5'd0, 5'd0);
        #2;
        check("t6_cnt4_full", 32'(retire_cnt4), 32'd15);
        drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h1, 32'd0, 32'd0, 5'd1, 5'd0, 5'd0, 5'd0);
        step(1'b1);
        idle(5'd0, 5'd0, 5'd0);
        #2;
        check("t6_cnt4_wrap", 32'(retire_cnt4), 32'd0);
        check("t6_cnt32", retire_cnt, 32'd16);
        step(1'b1);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] ins, rs, rt;
            ins = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            rs  = ($urandom_range(0, 2) == 0) ? ins : 5'($urandom);
            rt  = ($urandom_range(0, 2) == 0) ? ins : 5'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 4) == 0),
                  $urandom, $urandom, $urandom, ins, rs, rt, 5'($urandom));
            step(1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
